// File: rtl/dma_quiesce.sv
// Halt/quiet responder for one DMA direction: blocks issue on halt, drains in-flight work, reports quiet.
// Optional drain timeout enabled by defining DMA_QUIESCE_TIMEOUT_EN.
module dma_quiesce #(
    parameter int MAX_OUTSTANDING = 8,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1),
    parameter int TIMEOUT_CYC     = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dma_halt,
    input  logic             bus_req_fire,
    input  logic             bus_rsp_fire,
    output logic             issue_en,
    output logic             quiet,
    output logic [CNT_W-1:0] outstanding,
    output logic             protocol_err,
    output logic             halt_timeout
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_QUIET = 2'd2;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    if ((MAX_OUTSTANDING < 1) || (TIMEOUT_CYC < 1)) begin : g_bad_cfg
        $error("dma_quiesce: MAX_OUTSTANDING and TIMEOUT_CYC must be >= 1");
    end

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             quiet_q, quiet_d;
    logic             perr_q, perr_d;

`ifdef DMA_QUIESCE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             tflag_q, tflag_d;
    logic             tmo_hit_s;
    logic             tmo_fire_s;

    assign tmo_hit_s = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
`endif

    // Next-state for in-flight counter, sticky error flag and handshake FSM
    always_comb begin
        cnt_d   = cnt_q;
        perr_d  = perr_q;
        state_d = state_q;
`ifdef DMA_QUIESCE_TIMEOUT_EN
        tmo_fire_s = 1'b0;
`endif
        if (bus_req_fire && !bus_rsp_fire) begin
            if (cnt_q == CNT_MAX) begin
                perr_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (bus_rsp_fire && !bus_req_fire) begin
            if (cnt_q == CNT_ZERO) begin
                perr_d = 1'b1;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end

        case (state_q)
            ST_RUN: begin
                if (dma_halt) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (!dma_halt) begin
                    state_d = ST_RUN;
                end else if ((cnt_q == CNT_ZERO) && !bus_req_fire && !bus_rsp_fire) begin
                    state_d = ST_QUIET;
`ifdef DMA_QUIESCE_TIMEOUT_EN
                end else if (tmo_hit_s) begin
                    // Force quiet so the reset sequence cannot hang on a stuck fabric
                    state_d    = ST_QUIET;
                    cnt_d      = CNT_ZERO;
                    tmo_fire_s = 1'b1;
`endif
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_QUIET: begin
                if (!dma_halt) begin
                    state_d = ST_RUN;
                end else if (bus_req_fire) begin
                    state_d = ST_DRAIN;
                    perr_d  = 1'b1;
                end else begin
                    state_d = ST_QUIET;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        quiet_d = (state_d == ST_QUIET);
    end

`ifdef DMA_QUIESCE_TIMEOUT_EN
    // Drain timer: zero outside DRAIN, so entry to DRAIN always starts from zero
    always_comb begin
        if ((state_q == ST_DRAIN) && (state_d == ST_DRAIN)) begin
            tmo_d = tmo_q + TMO_W'(1);
        end else begin
            tmo_d = {TMO_W{1'b0}};
        end
        tflag_d = tflag_q | tmo_fire_s;
    end

    // Timeout counter and sticky timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q   <= {TMO_W{1'b0}};
            tflag_q <= 1'b0;
        end else begin
            tmo_q   <= tmo_d;
            tflag_q <= tflag_d;
        end
    end

    assign halt_timeout = tflag_q;
`else
    assign halt_timeout = 1'b0;
`endif

    // Core state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= CNT_ZERO;
            quiet_q <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quiet_q <= quiet_d;
            perr_q  <= perr_d;
        end
    end

    assign issue_en     = (state_q == ST_RUN) && !dma_halt && (cnt_q < CNT_MAX);
    assign quiet        = quiet_q;
    assign outstanding  = cnt_q;
    assign protocol_err = perr_q;

endmodule

// File: tb/tb_dma_quiesce.sv
// Randomized and directed bench for dma_quiesce against a behavioural model of the halt/quiet rules.
// Timeout expectations follow DMA_QUIESCE_TIMEOUT_EN when it is defined for the build.
module tb_dma_quiesce;

    localparam int MAXO  = 8;
    localparam int CW    = $clog2(MAXO + 1);
    localparam int TMO   = 16;

    localparam int P_ACTIVE   = 0;
    localparam int P_DRAINING = 1;
    localparam int P_DORMANT  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          dma_halt = 1'b0;
    logic          bus_req_fire = 1'b0;
    logic          bus_rsp_fire = 1'b0;
    logic          issue_en;
    logic          quiet;
    logic [CW-1:0] outstanding;
    logic          protocol_err;
    logic          halt_timeout;

    int checks = 0;
    int errors = 0;

    int m_cnt;
    int m_phase;
    int m_tcnt;
    bit m_perr;
    bit m_tmo;

    dma_quiesce #(.MAX_OUTSTANDING(MAXO), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .dma_halt(dma_halt),
        .bus_req_fire(bus_req_fire), .bus_rsp_fire(bus_rsp_fire),
        .issue_en(issue_en), .quiet(quiet), .outstanding(outstanding),
        .protocol_err(protocol_err), .halt_timeout(halt_timeout)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit model_issue(input bit h);
        return (m_phase == P_ACTIVE) && !h && (m_cnt < MAXO);
    endfunction

    function automatic void model_reset();
        m_cnt = 0; m_phase = P_ACTIVE; m_tcnt = 0; m_perr = 1'b0; m_tmo = 1'b0;
    endfunction

    function automatic void model_step(input bit h, input bit rq, input bit rs);
        int nc = m_cnt;
        if (rq && !rs) begin
            if (m_cnt == MAXO) m_perr = 1'b1; else nc = m_cnt + 1;
        end else if (rs && !rq) begin
            if (m_cnt == 0) m_perr = 1'b1; else nc = m_cnt - 1;
        end
        if (m_phase == P_ACTIVE) begin
            if (h) begin m_phase = P_DRAINING; m_tcnt = 0; end
        end else if (m_phase == P_DRAINING) begin
            if (!h) m_phase = P_ACTIVE;
            else if (m_cnt == 0 && !rq && !rs) m_phase = P_DORMANT;
            else begin
                m_tcnt = m_tcnt + 1;
`ifdef DMA_QUIESCE_TIMEOUT_EN
                if (m_tcnt == TMO) begin
                    m_phase = P_DORMANT; m_tmo = 1'b1; nc = 0;
                end
`endif
            end
        end else begin
            if (!h) m_phase = P_ACTIVE;
            else if (rq) begin m_phase = P_DRAINING; m_perr = 1'b1; m_tcnt = 0; end
        end
        m_cnt = nc;
    endfunction

    // One clock: drive, check outputs on the falling edge, advance model on the rising edge
    task automatic cyc(input bit h, input bit rq, input bit rs);
        dma_halt = h; bus_req_fire = rq; bus_rsp_fire = rs;
        @(negedge clk);
        check_val("issue_en", int'(issue_en), int'(model_issue(h)));
        check_val("quiet", int'(quiet), int'(m_phase == P_DORMANT));
        check_val("outstanding", int'(outstanding), m_cnt);
        check_val("protocol_err", int'(protocol_err), int'(m_perr));
        check_val("halt_timeout", int'(halt_timeout), int'(m_tmo));
        @(posedge clk);
        model_step(h, rq, rs);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; dma_halt = 1'b0; bus_req_fire = 1'b0; bus_rsp_fire = 1'b0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        bit h;
        bit rq;
        bit rs;
        do_reset();
        check_val("rst_outstanding", int'(outstanding), 0);
        check_val("rst_quiet", int'(quiet), 0);
        check_val("rst_issue_en", int'(issue_en), 1);

        // Idle halt: quiet two cycles after halt rises, drops one cycle after release
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        check_val("idle_quiet_n2", int'(quiet), 1);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        check_val("idle_quiet_m1", int'(quiet), 0);

        // Drain of five outstanding requests
        for (int i = 0; i < 5; i++) cyc(0, 1, 0);
        cyc(1, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 1);
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        check_val("drain_quiet", int'(quiet), 1);
        check_val("drain_perr", int'(protocol_err), 0);
        // Completion with nothing outstanding while quiet: error but stay quiet
        cyc(1, 0, 1);
        cyc(1, 0, 0);
        // Late request in quiet
        cyc(1, 1, 0);
        cyc(1, 0, 1);
        cyc(1, 0, 0);
        cyc(0, 0, 0);

        // Simultaneous req+rsp and overflow
        do_reset();
        for (int i = 0; i < 3; i++) cyc(0, 1, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 1);
        check_val("simul_hold", int'(outstanding), 3);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0);
        check_val("full_issue_en", int'(issue_en), 0);
        cyc(0, 1, 0);
        check_val("ovf_count", int'(outstanding), MAXO);
        check_val("ovf_perr", int'(protocol_err), 1);

        // Abort: halt for three cycles with work outstanding, then release
        do_reset();
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        check_val("abort_issue_en", int'(issue_en), 1);
        check_val("abort_quiet", int'(quiet), 0);

        // Stuck drain: one outstanding, halt held with no completion
        do_reset();
        cyc(0, 1, 0);
        for (int i = 0; i < TMO + 4; i++) cyc(1, 0, 0);
`ifdef DMA_QUIESCE_TIMEOUT_EN
        check_val("tmo_quiet", int'(quiet), 1);
        check_val("tmo_flag", int'(halt_timeout), 1);
`else
        check_val("tmo_quiet", int'(quiet), 0);
        check_val("tmo_flag", int'(halt_timeout), 0);
`endif
        cyc(1, 0, 1);
        cyc(1, 0, 0);

        // Async reset in the middle of a drain
        do_reset();
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        #2;
        rst = 1'b1; dma_halt = 1'b0; bus_req_fire = 1'b0; bus_rsp_fire = 1'b0;
        #1;
        check_val("arst_outstanding", int'(outstanding), 0);
        check_val("arst_quiet", int'(quiet), 0);
        check_val("arst_issue_en", int'(issue_en), 1);
        check_val("arst_perr", int'(protocol_err), 0);
        check_val("arst_tmo", int'(halt_timeout), 0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;

        // Randomized traffic with occasional protocol violations
        h = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 24) == 0) h = ~h;
            rq = model_issue(h) && ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 79) == 0) rq = 1'b1;
            rs = (m_cnt > 0) && ($urandom_range(0, 2) == 0);
            if (h && $urandom_range(0, 3) == 0) rs = 1'b0;
            if ($urandom_range(0, 89) == 0) rs = 1'b1;
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
                h = 1'b0;
            end else begin
                cyc(h, rq, rs);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
